// File: rtl/dot_matrix_scan_if.sv
// Host-side bus of the dot-matrix scan driver: code loading, scan control and LED drive outputs.
interface dot_matrix_scan_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 3
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] codes_in;
  logic                    load;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    pending;
  logic [4:0]              row_en;
  logic [3*NUM_DIGITS-1:0] col_data;
  logic                    frame_start;

  modport master (
    output enable, codes_in, load, brightness,
    input  pending, row_en, col_data, frame_start
  );

  modport slave (
    input  enable, codes_in, load, brightness,
    output pending, row_en, col_data, frame_start
  );
endinterface

// File: rtl/dot_matrix_scan_driver.sv
// Row-multiplexed 3x5 dot-matrix driver for NUM_DIGITS character cells with PWM
// brightness and frame-aligned, double-buffered code updates.
module dot_matrix_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ROW_HOLD   = 1024,
  parameter int unsigned BRIGHT_W   = 3
) (
  input logic              clk,
  input logic              rst_n,
  dot_matrix_scan_if.slave bus
);
  localparam int unsigned HOLD_W   = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam int unsigned CODE_W   = 4 * NUM_DIGITS;
  localparam int unsigned COL_W    = 3 * NUM_DIGITS;
  localparam logic [2:0]  ROW_LAST = 3'd4;

  logic [HOLD_W-1:0]   hold_cnt;
  logic [2:0]          row_cnt;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [CODE_W-1:0]   active;
  logic [CODE_W-1:0]   pending_buf;
  logic                pending_q;
  logic [4:0]          row_en_q;
  logic [COL_W-1:0]    col_data_q;
  logic                frame_start_q;

  logic                hold_end_c;
  logic                boundary_c;
  logic                commit_c;
  logic                lit_c;
  logic [4:0]          row_sel_c;
  logic [COL_W-1:0]    col_c;

  // Glyph ROM: 15 bits, row0..row4 from MSB, each row left..right.
  function automatic logic [14:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:  glyph = 15'b111_101_101_101_111;
      4'd1:  glyph = 15'b010_110_010_010_111;
      4'd2:  glyph = 15'b111_001_111_100_111;
      4'd3:  glyph = 15'b111_001_111_001_111;
      4'd4:  glyph = 15'b101_101_111_001_001;
      4'd5:  glyph = 15'b111_100_111_001_111;
      4'd6:  glyph = 15'b111_100_111_101_111;
      4'd7:  glyph = 15'b111_001_001_001_001;
      4'd8:  glyph = 15'b111_101_111_101_111;
      4'd9:  glyph = 15'b111_101_111_001_111;
      4'd10: glyph = 15'b000_000_000_000_010;
      4'd11: glyph = 15'b000_010_111_010_000;
      4'd12: glyph = 15'b000_000_111_000_000;
      4'd13: glyph = 15'b000_101_010_101_000;
      4'd14: glyph = 15'b000_000_010_000_000;
      4'd15: glyph = 15'b000_000_000_000_111;
    endcase
  endfunction

  function automatic logic [2:0] glyph_row(input logic [14:0] g, input logic [2:0] r);
    case (r)
      3'd0:    glyph_row = g[14:12];
      3'd1:    glyph_row = g[11:9];
      3'd2:    glyph_row = g[8:6];
      3'd3:    glyph_row = g[5:3];
      default: glyph_row = g[2:0];
    endcase
  endfunction

  // Scan position decode and column pattern for the current row.
  always_comb begin
    hold_end_c = (hold_cnt == HOLD_W'(ROW_HOLD - 1));
    boundary_c = hold_end_c && (row_cnt == ROW_LAST);
    commit_c   = pending_q && (boundary_c || !bus.enable);
    lit_c      = bus.enable && (pwm_cnt <= bus.brightness);
    row_sel_c  = 5'd1 << row_cnt;
    col_c      = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      col_c[3*d +: 3] = glyph_row(glyph(active[4*d +: 4]), row_cnt);
    end
  end

  // Scan counters; parked at zero while disabled so re-enable restarts at row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      row_cnt  <= '0;
      pwm_cnt  <= '0;
    end else if (!bus.enable) begin
      hold_cnt <= '0;
      row_cnt  <= '0;
      pwm_cnt  <= '0;
    end else if (hold_end_c) begin
      hold_cnt <= '0;
      pwm_cnt  <= '0;
      row_cnt  <= (row_cnt == ROW_LAST) ? 3'd0 : row_cnt + 3'd1;
    end else begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
      pwm_cnt  <= pwm_cnt + BRIGHT_W'(1);
    end
  end

  // Double buffer: a load landing on a commit cycle stays pending for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= '0;
      pending_buf <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (commit_c) begin
        active <= pending_buf;
      end
      if (bus.load) begin
        pending_buf <= bus.codes_in;
        pending_q   <= 1'b1;
      end else if (commit_c) begin
        pending_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_en_q      <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      row_en_q      <= lit_c ? row_sel_c : 5'd0;
      col_data_q    <= lit_c ? col_c : '0;
      frame_start_q <= bus.enable && (hold_cnt == '0) && (row_cnt == 3'd0);
    end
  end

  assign bus.row_en      = row_en_q;
  assign bus.col_data    = col_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;
endmodule

// File: tb/tb_dot_matrix_scan_driver.sv
// Bench for dot_matrix_scan_driver: directed scenarios plus random traffic, checked every
// cycle against a frame-time reference model of the display.
module tb_dot_matrix_scan_driver;
  localparam int unsigned ND    = 2;
  localparam int unsigned RH    = 16;
  localparam int unsigned BW    = 3;
  localparam int unsigned FRAME = 5 * RH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dot_matrix_scan_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

  dot_matrix_scan_driver #(.NUM_DIGITS(ND), .ROW_HOLD(RH), .BRIGHT_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [14:0]     font [16];
  int              vectors     = 0;
  int              miscompares = 0;

  // Reference model: position within the frame plus displayed/pending codes.
  int              scan_t;
  logic [3:0]      act  [ND];
  logic [3:0]      pbuf [ND];
  logic            pend;
  logic [4:0]      exp_row;
  logic [3*ND-1:0] exp_col;
  logic            exp_fs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    scan_t  = 0;
    pend    = 1'b0;
    exp_row = '0;
    exp_col = '0;
    exp_fs  = 1'b0;
    for (int d = 0; d < ND; d++) begin
      act[d]  = 4'd0;
      pbuf[d] = 4'd0;
    end
  endtask

  task automatic model_step(input logic en, input logic ld, input logic [4*ND-1:0] codes,
                            input logic [BW-1:0] br);
    int   row;
    int   hold;
    logic boundary;
    logic commit;
    logic lit;
    exp_row  = '0;
    exp_col  = '0;
    exp_fs   = 1'b0;
    boundary = 1'b0;
    if (en) begin
      row  = (scan_t / RH) % 5;
      hold = scan_t % RH;
      lit  = (hold % (1 << BW)) <= int'(br);
      if (lit) begin
        exp_row = 5'(1 << row);
        for (int d = 0; d < ND; d++) exp_col[3*d +: 3] = 3'(font[act[d]] >> (12 - 3*row));
      end
      exp_fs   = (scan_t == 0);
      boundary = (scan_t == FRAME - 1);
    end
    commit = pend && (boundary || !en);
    if (commit) for (int d = 0; d < ND; d++) act[d] = pbuf[d];
    if (ld) begin
      for (int d = 0; d < ND; d++) pbuf[d] = codes[4*d +: 4];
      pend = 1'b1;
    end else if (commit) begin
      pend = 1'b0;
    end
    scan_t = en ? (scan_t + 1) % FRAME : 0;
  endtask

  task automatic cycle(input logic en, input logic ld, input logic [4*ND-1:0] codes,
                       input logic [BW-1:0] br);
    bus.enable     = en;
    bus.load       = ld;
    bus.codes_in   = codes;
    bus.brightness = br;
    @(posedge clk);
    model_step(en, ld, codes, br);
    #1;
    check("row_en",      32'(bus.row_en),      32'(exp_row));
    check("col_data",    32'(bus.col_data),    32'(exp_col));
    check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    check("pending",     32'(bus.pending),     32'(pend));
  endtask

  task automatic idle(input int n, input logic en, input logic [BW-1:0] br);
    for (int i = 0; i < n; i++) cycle(en, 1'b0, (4*ND)'($urandom), br);
  endtask

  // Runs enabled cycles until the model sits at the given frame position (bounded).
  task automatic advance_to(input int target, input logic [BW-1:0] br);
    for (int i = 0; i <= int'(FRAME) && scan_t != target; i++) cycle(1'b1, 1'b0, (4*ND)'($urandom), br);
    check("advance_to", 32'(scan_t), 32'(target));
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_row_en",      32'(bus.row_en),      32'd0);
    check("rst_col_data",    32'(bus.col_data),    32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    check("rst_pending",     32'(bus.pending),     32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lit_count(input logic [BW-1:0] br, input int want, input string tag);
    int n = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      cycle(1'b1, 1'b0, (4*ND)'($urandom), br);
      if (bus.row_en != 5'd0) n++;
    end
    check(tag, 32'(n), 32'(want));
  endtask

  initial begin
    font[0]  = 15'b111_101_101_101_111;  font[1]  = 15'b010_110_010_010_111;
    font[2]  = 15'b111_001_111_100_111;  font[3]  = 15'b111_001_111_001_111;
    font[4]  = 15'b101_101_111_001_001;  font[5]  = 15'b111_100_111_001_111;
    font[6]  = 15'b111_100_111_101_111;  font[7]  = 15'b111_001_001_001_001;
    font[8]  = 15'b111_101_111_101_111;  font[9]  = 15'b111_101_111_001_111;
    font[10] = 15'b000_000_000_000_010;  font[11] = 15'b000_010_111_010_000;
    font[12] = 15'b000_000_111_000_000;  font[13] = 15'b000_101_010_101_000;
    font[14] = 15'b000_000_010_000_000;  font[15] = 15'b000_000_000_000_111;

    bus.enable = 1'b1; bus.load = 1'b0; bus.codes_in = '0; bus.brightness = 3'd7;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("init_row_en",  32'(bus.row_en),  32'd0);
    check("init_pending", 32'(bus.pending), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full brightness, "00" scanned for two frames.
    idle(2 * FRAME + 3, 1'b1, 3'd7);

    // Load plus/minus mid-row 2; commits at the next boundary.
    advance_to(2*RH + 5, 3'd7);
    cycle(1'b1, 1'b1, 8'hBC, 3'd7);
    idle(2 * FRAME, 1'b1, 3'd7);

    // Two loads in one frame: only the latest is ever shown.
    advance_to(RH, 3'd7);
    cycle(1'b1, 1'b1, 8'h12, 3'd7);
    idle(7, 1'b1, 3'd7);
    cycle(1'b1, 1'b1, 8'h34, 3'd7);
    idle(2 * FRAME, 1'b1, 3'd7);

    // Load on the exact boundary cycle after an earlier load.
    advance_to(10, 3'd7);
    cycle(1'b1, 1'b1, 8'h55, 3'd7);
    advance_to(FRAME - 1, 3'd7);
    cycle(1'b1, 1'b1, 8'h9E, 3'd7);
    check("boundary_pending", 32'(bus.pending), 32'd1);
    idle(2 * FRAME + 1, 1'b1, 3'd7);

    // PWM duty: lit cycles per frame.
    lit_count(3'd0, 10, "lit_b0");
    lit_count(3'd3, 40, "lit_b3");
    lit_count(3'd7, 80, "lit_b7");

    // Async reset during row 3 with a load pending.
    cycle(1'b1, 1'b1, 8'h77, 3'd7);
    advance_to(3*RH + 4, 3'd7);
    async_reset();
    idle(FRAME + 2, 1'b1, 3'd7);

    // Enable dropped in row 1, load while disabled, re-enable.
    advance_to(RH + 3, 3'd7);
    idle(4, 1'b0, 3'd7);
    cycle(1'b0, 1'b1, 8'hD8, 3'd7);
    idle(3, 1'b0, 3'd7);
    idle(FRAME + 2, 1'b1, 3'd7);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic            en;
      logic            ld;
      logic [BW-1:0]   br;
      if ($urandom_range(0, 1499) == 0) async_reset();
      en = ($urandom_range(0, 99) >= 3);
      ld = ($urandom_range(0, 39) == 0);
      br = (i % 200 < 100) ? 3'd7 : BW'($urandom);
      cycle(en, ld, (4*ND)'($urandom), br);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
